shamt_scheduler: RTL and testbench

- Sequences one FFT stage's block-floating-point scan.
- Reads the stage's sample memory 4 words per beat and streams the beats into the 4-lane shamt producer.
- Collects the per-lane shift amounts it returns and reduces them to one stage-wide shamt.
- Accumulates that shamt into the running block exponent. Sits between the in-place data memory and the shamt producer, under the FFT top-level controller.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/scan_fifo2.sv | 45 ++++
 rtl/shamt_scheduler.sv | 136 +++++++++++++
 tb/tb_shamt_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT block-floating-point types and helpers.
// Holds the scan FSM state type, the lane-minimum reducer and the legal sample/shamt width pairs.
// Pure declarations: no latency, no flow control.
package fft_pkg;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} scan_state_t;

    // Widest shamt code in use; narrower codes are zero-extended before reduction.
    localparam int SHAMT_MAX = 5;

    function automatic bit shamt_pair_ok(input int w, input int s);
        return (w == 8 && s == 4) || (w == 16 && s == 5);
    endfunction

    function automatic logic [SHAMT_MAX-1:0] min4(input logic [SHAMT_MAX-1:0] a,
                                                  input logic [SHAMT_MAX-1:0] b,
                                                  input logic [SHAMT_MAX-1:0] c,
                                                  input logic [SHAMT_MAX-1:0] d);
        logic [SHAMT_MAX-1:0] ab;
        logic [SHAMT_MAX-1:0] cd;
        ab = (a < b) ? a : b;
        cd = (c < d) ? c : d;
        return (ab < cd) ? ab : cd;
    endfunction

endpackage

// File: rtl/scan_fifo2.sv
// Two-entry read-data buffer between the sample memory and the shamt producer.
// Latency: a push is visible at dout the cycle after it is written.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module scan_fifo2 #(
    parameter int dw = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [dw-1:0] din,
    output logic [dw-1:0] dout,
    output logic [1:0]    count
);

    logic [dw-1:0] slot [2];
    logic          wptr;
    logic          rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wptr] <= din;
                wptr       <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout = slot[rptr];

endmodule

// File: rtl/shamt_scheduler.sv
// Sequences one FFT stage scan: memory reads -> producer beats, lane shamts -> stage minimum -> block exponent.
// Latency: first read the cycle after start_i is accepted; done_o one cycle after the last result handshake.
// Backpressure: reads throttle so buffered plus in-flight beats never exceed two; results accepted while scanning.
module shamt_scheduler
    import fft_pkg::*;
#(
    parameter int width     = 8,
    parameter int shamtbits = 4,
    parameter int points    = 64,
    parameter int expbits   = 8,
    localparam int addrbits = $clog2(points / 4)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   exp_clr_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   mem_rd_en_o,
    output logic [addrbits-1:0]    mem_addr_o,
    input  logic [4*width-1:0]     mem_data_i,
    output logic                   p_tvalid_o,
    output logic                   p_tlast_o,
    input  logic                   p_tready_i,
    output logic [4*width-1:0]     p_data_o,
    input  logic                   r_tvalid_i,
    input  logic                   r_tlast_i,
    output logic                   r_tready_o,
    input  logic [4*shamtbits-1:0] r_shamt_i,
    output logic [shamtbits-1:0]   stage_shamt_o,
    output logic [expbits-1:0]     exp_acc_o
);

    if (!shamt_pair_ok(width, shamtbits)) begin : g_bad_pair
        $error("shamt_scheduler: unsupported width/shamtbits pair");
    end
    if (points < 16 || points > 4096 || (points & (points - 1)) != 0) begin : g_bad_points
        $error("shamt_scheduler: points must be a power of 2 in 16..4096");
    end

    localparam logic [addrbits-1:0]  last_beat = addrbits'(points / 4 - 1);
    localparam logic [SHAMT_MAX-1:0] min_init  = SHAMT_MAX'((1 << shamtbits) - 1);

    scan_state_t          state;
    scan_state_t          state_nxt;
    logic [addrbits-1:0]  rd_cnt;
    logic [addrbits-1:0]  wr_cnt;
    logic [addrbits-1:0]  res_cnt;
    logic [SHAMT_MAX-1:0] run_min;
    logic [SHAMT_MAX-1:0] lane_min;
    logic [expbits:0]     exp_sum;
    logic [1:0]           fifo_count;
    logic                 inflight;
    logic                 pop;
    logic                 r_hs;
    logic                 last_res;

    scan_fifo2 #(.dw(4 * width)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (mem_data_i),
        .dout  (p_data_o),
        .count (fifo_count)
    );

    assign mem_rd_en_o = (state == FEED) && ((fifo_count + 2'(inflight)) < 2'd2);
    assign mem_addr_o  = rd_cnt;
    assign p_tvalid_o  = (fifo_count != 2'd0);
    assign p_tlast_o   = p_tvalid_o && (wr_cnt == last_beat);
    assign pop         = p_tvalid_o & p_tready_i;
    assign r_tready_o  = (state == FEED) || (state == DRAIN);
    assign r_hs        = r_tvalid_i & r_tready_o;
    assign last_res    = (res_cnt == last_beat);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);

    assign lane_min = min4(SHAMT_MAX'(r_shamt_i[0*shamtbits +: shamtbits]),
                           SHAMT_MAX'(r_shamt_i[1*shamtbits +: shamtbits]),
                           SHAMT_MAX'(r_shamt_i[2*shamtbits +: shamtbits]),
                           SHAMT_MAX'(r_shamt_i[3*shamtbits +: shamtbits]));

    // One extra bit catches the carry so the exponent pins at all-ones.
    assign exp_sum = {1'b0, exp_acc_o} + (expbits + 1)'(run_min);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = FEED;
            FEED:    if (mem_rd_en_o && rd_cnt == last_beat) state_nxt = DRAIN;
            DRAIN:   if (r_hs && last_res) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            res_cnt       <= '0;
            run_min       <= min_init;
            inflight      <= 1'b0;
            err_o         <= 1'b0;
            stage_shamt_o <= '1;
            exp_acc_o     <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= mem_rd_en_o;
            if (state == IDLE && start_i) begin
                rd_cnt  <= '0;
                wr_cnt  <= '0;
                res_cnt <= '0;
                run_min <= min_init;
            end else begin
                if (mem_rd_en_o) rd_cnt <= rd_cnt + 1'b1;
                if (pop)         wr_cnt <= wr_cnt + 1'b1;
                if (r_hs) begin
                    res_cnt <= res_cnt + 1'b1;
                    run_min <= (lane_min < run_min) ? lane_min : run_min;
                    if (r_tlast_i != last_res) err_o <= 1'b1;
                end
            end
            if (state == DONE) stage_shamt_o <= run_min[shamtbits-1:0];
            if (exp_clr_i) begin
                exp_acc_o <= '0;
            end else if (state == DONE) begin
                exp_acc_o <= exp_sum[expbits] ? '1 : exp_sum[expbits-1:0];
            end
        end
    end

endmodule

// File: tb/tb_shamt_scheduler.sv
// Directed bench for shamt_scheduler: memory and producer are modelled inline, each scenario checks its own results.
module tb_shamt_scheduler;

    localparam int BEATS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        exp_clr_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        mem_rd_en_o;
    logic [3:0]  mem_addr_o;
    logic [31:0] mem_data_i;
    logic        p_tvalid_o;
    logic        p_tlast_o;
    logic        p_tready_i;
    logic [31:0] p_data_o;
    logic        r_tvalid_i;
    logic        r_tlast_i;
    logic        r_tready_o;
    logic [15:0] r_shamt_i;
    logic [3:0]  stage_shamt_o;
    logic [7:0]  exp_acc_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] words   [BEATS];
    logic [15:0] res_tab [BEATS];
    int          bad_last_idx = -1;

    logic [31:0] obs_data [BEATS];
    logic        obs_last [BEATS];
    logic [3:0]  obs_addr [BEATS];
    int          n_rd, n_pop, n_res, n_done, n_viol, n_busy_bad, timed_out;
    logic        lat_rd;
    logic [3:0]  lat_addr;

    always #5 clk = ~clk;

    shamt_scheduler #(.width(8), .shamtbits(4), .points(64), .expbits(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .exp_clr_i     (exp_clr_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_i    (mem_data_i),
        .p_tvalid_o    (p_tvalid_o),
        .p_tlast_o     (p_tlast_o),
        .p_tready_i    (p_tready_i),
        .p_data_o      (p_data_o),
        .r_tvalid_i    (r_tvalid_i),
        .r_tlast_i     (r_tlast_i),
        .r_tready_o    (r_tready_o),
        .r_shamt_i     (r_shamt_i),
        .stage_shamt_o (stage_shamt_o),
        .exp_acc_o     (exp_acc_o)
    );

    function automatic logic [15:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {4'(l3), 4'(l2), 4'(l1), 4'(l0)};
    endfunction

    task automatic set_table(input logic [15:0] base, input int sp_idx, input logic [15:0] sp);
        for (int i = 0; i < BEATS; i++) res_tab[i] = (i == sp_idx) ? sp : base;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 1'b0; exp_clr_i = 1'b0; p_tready_i = 1'b0;
        r_tvalid_i = 1'b0; r_tlast_i = 1'b0; r_shamt_i = '0; mem_data_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one scan; mode 1 toggles p_tready_i 1,0,0,1. Stops after done_o or after abort_after results.
    task automatic drive_scan(input int mode, input int abort_after, input bit clr_in_done);
        int         occ, pend;
        bit         prev_rd, pop, rhs, was_done, stop;
        logic [3:0] prev_addr;
        occ = 0; pend = 0; prev_rd = 1'b0; prev_addr = '0; stop = 1'b0;
        n_rd = 0; n_pop = 0; n_res = 0; n_done = 0; n_viol = 0; n_busy_bad = 0; timed_out = 1;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; lat_rd = mem_rd_en_o; lat_addr = mem_addr_o;
        for (int cyc = 0; cyc < 600 && !stop; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mem_data_i = prev_rd ? words[prev_addr] : 32'hDEAD_BEEF;
            was_done   = done_o;
            if (done_o) n_done++;
            exp_clr_i = clr_in_done & done_o;
            if (!busy_o) n_busy_bad++;
            if (mem_rd_en_o && (occ + int'(prev_rd) >= 2)) n_viol++;
            if (p_tvalid_o !== (occ > 0)) n_viol++;
            p_tready_i = (mode == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
            pop        = p_tvalid_o & p_tready_i;
            r_tvalid_i = (pend > 0);
            r_shamt_i  = res_tab[n_res % BEATS];
            r_tlast_i  = (n_res == BEATS - 1) || (n_res == bad_last_idx);
            rhs        = r_tvalid_i & r_tready_o;
            if (mem_rd_en_o) begin
                if (n_rd < BEATS) obs_addr[n_rd] = mem_addr_o;
                n_rd++;
            end
            if (pop) begin
                if (n_pop < BEATS) begin
                    obs_data[n_pop] = p_data_o;
                    obs_last[n_pop] = p_tlast_o;
                end
                n_pop++;
            end
            if (rhs) begin n_res++; pend--; end
            if (pop) pend++;
            occ       = occ + int'(prev_rd) - int'(pop);
            prev_rd   = mem_rd_en_o;
            prev_addr = mem_addr_o;
            @(posedge clk); #1;
            if (was_done || (abort_after >= 0 && n_res == abort_after)) begin
                stop = 1'b1; timed_out = 0;
            end
        end
        exp_clr_i = 1'b0; p_tready_i = 1'b0; r_tvalid_i = 1'b0; r_tlast_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({busy_o, done_o, err_o, mem_rd_en_o, p_tvalid_o, p_tlast_o, r_tready_o} !== 7'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 0000000", {busy_o, done_o, err_o, mem_rd_en_o, p_tvalid_o, p_tlast_o, r_tready_o});
        end
        tests++;
        if ({mem_addr_o, p_data_o} !== 36'h0) begin
            fails++; $display("FAIL reset_data: addr %h data %h want 0", mem_addr_o, p_data_o);
        end
        tests++;
        if (stage_shamt_o !== 4'hF) begin fails++; $display("FAIL reset_stage: got %h want f", stage_shamt_o); end
        tests++;
        if (exp_acc_o !== 8'd0) begin fails++; $display("FAIL reset_exp: got %0d want 0", exp_acc_o); end
    endtask

    task automatic test_basic_scan();
        set_table(pk(5, 3, 6, 4), 9, pk(2, 7, 7, 7));
        drive_scan(0, -1, 1'b0);
        tests++;
        if (timed_out !== 0) begin fails++; $display("FAIL basic_timeout: no done_o within budget"); end
        tests++;
        if ({lat_rd, lat_addr} !== 5'b1_0000) begin
            fails++; $display("FAIL basic_first_read: rd %b addr %0d want 1 at 0", lat_rd, lat_addr);
        end
        tests++;
        if (n_rd !== BEATS) begin fails++; $display("FAIL basic_reads: got %0d want %0d", n_rd, BEATS); end
        for (int i = 0; i < BEATS; i++) begin
            tests++;
            if (obs_addr[i] !== 4'(i)) begin fails++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, obs_addr[i], i); end
        end
        for (int i = 0; i < BEATS; i++) begin
            tests++;
            if (obs_last[i] !== (i == BEATS - 1)) begin
                fails++; $display("FAIL basic_tlast[%0d]: got %b want %b", i, obs_last[i], i == BEATS - 1);
            end
        end
        tests++;
        if (n_done !== 1) begin fails++; $display("FAIL basic_done: got %0d pulses want 1", n_done); end
        tests++;
        if (stage_shamt_o !== 4'd2) begin fails++; $display("FAIL basic_stage: got %0d want 2", stage_shamt_o); end
        tests++;
        if (exp_acc_o !== 8'd2) begin fails++; $display("FAIL basic_exp: got %0d want 2", exp_acc_o); end
        tests++;
        if ({err_o, busy_o} !== 2'b00) begin fails++; $display("FAIL basic_err_busy: got %b want 00", {err_o, busy_o}); end
        tests++;
        if (n_busy_bad !== 0) begin fails++; $display("FAIL basic_busy_gap: %0d cycles low want 0", n_busy_bad); end
        tests++;
        if (n_viol !== 0) begin fails++; $display("FAIL basic_fifo_rule: %0d violations want 0", n_viol); end
    endtask

    task automatic test_backpressure();
        set_table(pk(5, 3, 6, 4), 9, pk(2, 7, 7, 7));
        drive_scan(1, -1, 1'b0);
        tests++;
        if (timed_out !== 0) begin fails++; $display("FAIL bp_timeout: no done_o within budget"); end
        tests++;
        if (n_viol !== 0) begin fails++; $display("FAIL bp_fifo_rule: %0d violations want 0", n_viol); end
        tests++;
        if ({n_rd, n_pop} !== {BEATS, BEATS}) begin
            fails++; $display("FAIL bp_counts: reads %0d beats %0d want %0d each", n_rd, n_pop, BEATS);
        end
        for (int i = 0; i < BEATS; i++) begin
            tests++;
            if (obs_data[i] !== words[i]) begin fails++; $display("FAIL bp_data[%0d]: got %h want %h", i, obs_data[i], words[i]); end
        end
        tests++;
        if (obs_last[BEATS-1] !== 1'b1) begin fails++; $display("FAIL bp_tlast: got %b want 1", obs_last[BEATS-1]); end
        tests++;
        if ({n_done, stage_shamt_o} !== {32'd1, 4'd2}) begin
            fails++; $display("FAIL bp_result: done %0d stage %0d want 1 and 2", n_done, stage_shamt_o);
        end
    endtask

    task automatic test_accumulate();
        logic [15:0] bases [3];
        int          sp_idx [3];
        logic [15:0] sps [3];
        logic [7:0]  want [3];
        bases  = '{pk(5, 3, 6, 4), pk(4, 9, 8, 5), pk(6, 6, 6, 6)};
        sp_idx = '{-1, -1, 12};
        sps    = '{16'h0, 16'h0, pk(9, 1, 8, 9)};
        want   = '{8'd3, 8'd7, 8'd8};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            set_table(bases[s], sp_idx[s], sps[s]);
            drive_scan(0, -1, 1'b0);
            tests++;
            if (exp_acc_o !== want[s]) begin fails++; $display("FAIL acc_exp[%0d]: got %0d want %0d", s, exp_acc_o, want[s]); end
        end
        set_table(pk(7, 2, 9, 3), -1, 16'h0);
        drive_scan(0, -1, 1'b1);
        tests++;
        if (exp_acc_o !== 8'd0) begin fails++; $display("FAIL acc_clr_exp: got %0d want 0", exp_acc_o); end
        tests++;
        if (stage_shamt_o !== 4'd2) begin fails++; $display("FAIL acc_clr_stage: got %0d want 2", stage_shamt_o); end
    endtask

    task automatic test_saturate();
        do_reset();
        set_table(pk(15, 15, 15, 15), -1, 16'h0);
        for (int s = 0; s < 16; s++) drive_scan(0, -1, 1'b0);
        set_table(pk(10, 12, 11, 13), -1, 16'h0);
        drive_scan(0, -1, 1'b0);
        tests++;
        if (exp_acc_o !== 8'd250) begin fails++; $display("FAIL sat_preload: got %0d want 250", exp_acc_o); end
        set_table(pk(15, 15, 15, 15), -1, 16'h0);
        drive_scan(0, -1, 1'b0);
        tests++;
        if ({exp_acc_o, stage_shamt_o} !== {8'd255, 4'd15}) begin
            fails++; $display("FAIL sat_clip: exp %0d stage %0d want 255 and 15", exp_acc_o, stage_shamt_o);
        end
        set_table(pk(3, 1, 2, 4), -1, 16'h0);
        drive_scan(0, -1, 1'b0);
        tests++;
        if (exp_acc_o !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d want 255", exp_acc_o); end
    endtask

    task automatic test_tlast_err();
        do_reset();
        set_table(pk(5, 3, 6, 4), 9, pk(2, 7, 7, 7));
        bad_last_idx = 7;
        drive_scan(0, -1, 1'b0);
        bad_last_idx = -1;
        tests++;
        if ({timed_out, n_done} !== {32'd0, 32'd1}) begin
            fails++; $display("FAIL tlast_complete: timeout %0d done %0d want 0 and 1", timed_out, n_done);
        end
        tests++;
        if (err_o !== 1'b1) begin fails++; $display("FAIL tlast_err: got %b want 1", err_o); end
        drive_scan(0, -1, 1'b0);
        tests++;
        if ({err_o, n_done} !== {1'b1, 32'd1}) begin
            fails++; $display("FAIL tlast_sticky: err %b done %0d want 1 and 1", err_o, n_done);
        end
    endtask

    task automatic test_reset_mid_scan();
        int late_done;
        set_table(pk(5, 3, 6, 4), 9, pk(2, 7, 7, 7));
        drive_scan(0, 5, 1'b0);
        tests++;
        if (timed_out !== 0) begin fails++; $display("FAIL mid_reach5: only %0d results", n_res); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({busy_o, done_o, err_o, mem_rd_en_o, p_tvalid_o, p_tlast_o, r_tready_o} !== 7'b0) begin
            fails++; $display("FAIL mid_ctrl: got %b want 0000000", {busy_o, done_o, err_o, mem_rd_en_o, p_tvalid_o, p_tlast_o, r_tready_o});
        end
        tests++;
        if ({stage_shamt_o, exp_acc_o, mem_addr_o} !== {4'hF, 8'd0, 4'd0}) begin
            fails++; $display("FAIL mid_regs: stage %h exp %0d addr %0d want f 0 0", stage_shamt_o, exp_acc_o, mem_addr_o);
        end
        rst = 1'b0;
        late_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o) late_done++;
        end
        tests++;
        if (late_done !== 0) begin fails++; $display("FAIL mid_no_done: got %0d pulses want 0", late_done); end
        drive_scan(0, -1, 1'b0);
        tests++;
        if ({n_done, stage_shamt_o, exp_acc_o, err_o} !== {32'd1, 4'd2, 8'd2, 1'b0}) begin
            fails++; $display("FAIL mid_restart: done %0d stage %0d exp %0d err %b want 1 2 2 0", n_done, stage_shamt_o, exp_acc_o, err_o);
        end
    endtask

    initial begin
        for (int i = 0; i < BEATS; i++) words[i] = {8'(4*i+3) ^ 8'hA5, 8'(4*i+2), 8'(4*i+1) ^ 8'h3C, 8'(4*i)};
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_accumulate();
        test_saturate();
        test_tlast_err();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
